// File: rtl/cmp_controller_if.sv
// cmp_controller_if: requester-side handshake and registered result bundle for cmp_controller.
interface cmp_controller_if;
    logic        req0, req1, w0, w1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, busy, done, done_id, gt, eq, lt;
    modport master (output req0, req1, w0, w1, a0, b0, a1, b1,
                    input  gnt0, gnt1, busy, done, done_id, gt, eq, lt);
    modport slave  (input  req0, req1, w0, w1, a0, b0, a1, b1,
                    output gnt0, gnt1, busy, done, done_id, gt, eq, lt);
endinterface

// File: rtl/cmp_controller.sv
// cmp_controller: arbitrates two requesters onto one shared 8-bit comparator, high byte first for words.
module cmp_controller #(
    parameter int FIXED_PRIO = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cmp_controller_if.slave         bus,
    output logic [7:0]              cmp_a,
    output logic [7:0]              cmp_b,
    input  logic                    cmp_bigger,
    input  logic                    cmp_equal,
    input  logic                    cmp_smallest
);
    typedef enum logic [1:0] {IDLE, HI, LO} state_t;
    state_t      state, nxt;
    logic [15:0] ca, cb;
    logic        id, last, pick, win, fin, c_gt, c_lt, c_eq;
    always_comb begin
        c_gt  = cmp_bigger;
        c_lt  = !cmp_bigger && cmp_smallest;
        c_eq  = cmp_equal || !(cmp_bigger || cmp_smallest);
        pick  = state == IDLE && (bus.req0 || bus.req1);
        // win: 0 = requester 0, 1 = requester 1
        win   = (FIXED_PRIO != 0) ? !bus.req0 : (bus.req0 && bus.req1) ? !last : bus.req1;
        fin   = state == LO || (state == HI && (c_gt || c_lt));
        nxt   = state;
        if (pick)
            nxt = (win ? bus.w1 : bus.w0) ? HI : LO;
        else if (fin)
            nxt = IDLE;
        else if (state == HI)
            nxt = LO;
        cmp_a = state == HI ? ca[15:8] : state == LO ? ca[7:0] : 8'h00;
        cmp_b = state == HI ? cb[15:8] : state == LO ? cb[7:0] : 8'h00;
    end
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca          <= '0;
            cb          <= '0;
            id          <= 1'b0;
            last        <= 1'b1;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.gt      <= 1'b0;
            bus.eq      <= 1'b0;
            bus.lt      <= 1'b0;
        end else begin
            bus.gnt0 <= pick && !win;
            bus.gnt1 <= pick && win;
            bus.done <= fin;
            if (pick) begin
                ca   <= win ? bus.a1 : bus.a0;
                cb   <= win ? bus.b1 : bus.b0;
                id   <= win;
                last <= win;
            end
            if (fin) begin
                bus.gt      <= c_gt;
                bus.lt      <= c_lt;
                bus.eq      <= !c_gt && !c_lt && c_eq;
                bus.done_id <= id;
            end
        end
    end
endmodule
